// File: rtl/axis_packet_checksum.sv
// rtl/axis_packet_checksum.sv - 64-bit AXI-Stream pass-through that replaces tlast with a count/checksum trailer word
// Optional byte reversal of input words: define FLIP_EN.
module axis_packet_checksum #(
  parameter int C_AXIS_DATA_WIDTH = 64,
  parameter int C_CNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         pkt_done,
  output logic [C_CNT_WIDTH-1:0]       pkt_count,
  output logic                         busy
);

  typedef enum logic {PASS, TRAILER} state_t;

  state_t                         state_q;
  logic [C_AXIS_DATA_WIDTH-1:0]   tdata_q;
  logic [C_AXIS_DATA_WIDTH-1:0]   sum_q;
  logic [C_AXIS_DATA_WIDTH-1:0]   sum_d;
  logic [C_AXIS_DATA_WIDTH-1:0]   data_in;
  logic [C_AXIS_DATA_WIDTH-1:0]   trailer;
  logic [C_CNT_WIDTH-1:0]         wcnt_q;
  logic [C_CNT_WIDTH-1:0]         wcnt_d;
  logic [C_CNT_WIDTH-1:0]         pkt_count_q;
  logic                           tlast_q;
  logic                           tvalid_q;
  logic                           pkt_done_q;
  logic                           busy_q;
  logic                           out_free;
  logic                           in_hs;
  logic                           trl_hs;

`ifdef FLIP_EN
  always_comb begin
    data_in = '0;
    for (int i = 0; i < 8; i++) begin
      data_in[8*i +: 8] = s_axis_tdata[8*(7-i) +: 8];
    end
  end
`else
  assign data_in = s_axis_tdata;
`endif

  assign out_free      = !tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == PASS) && out_free;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign trl_hs        = tvalid_q && m_axis_tready && tlast_q;
  assign sum_d         = sum_q + data_in;
  assign wcnt_d        = wcnt_q + 1'b1;
  assign trailer       = {32'(wcnt_q), sum_q[63:32] ^ sum_q[31:0]};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= PASS;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      sum_q       <= '0;
      wcnt_q      <= '0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      if (trl_hs) begin
        pkt_done_q  <= 1'b1;
        pkt_count_q <= pkt_count_q + 1'b1;
        busy_q      <= 1'b0;
      end
      case (state_q)
        PASS: begin
          // A first word accepted alongside the trailer handshake keeps busy high.
          if (in_hs) begin
            tdata_q  <= data_in;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b1;
            sum_q    <= sum_d;
            wcnt_q   <= wcnt_d;
            busy_q   <= 1'b1;
            if (s_axis_tlast) state_q <= TRAILER;
          end else if (out_free) begin
            tvalid_q <= 1'b0;
          end
        end
        TRAILER: begin
          if (out_free) begin
            tdata_q  <= trailer;
            tlast_q  <= 1'b1;
            tvalid_q <= 1'b1;
            sum_q    <= '0;
            wcnt_q   <= '0;
            state_q  <= PASS;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_count     = pkt_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_packet_checksum.sv
// tb/tb_axis_packet_checksum.sv - table-driven and randomized checks of axis_packet_checksum against a packet-level model
module tb_axis_packet_checksum;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        pkt_done;
  logic [31:0] pkt_count;
  logic        busy;

  always #5 clk = ~clk;

  axis_packet_checksum #(.C_AXIS_DATA_WIDTH(64), .C_CNT_WIDTH(32)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_done(pkt_done), .pkt_count(pkt_count), .busy(busy)
  );

  typedef struct {
    int               n;
    logic [3:0][63:0] w;
    logic [63:0]      trl;
  } vec_t;

  vec_t        tbl[4];
  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];
  logic [63:0] pkt_q[$];
  int          g_rd = 0, e_rd = 0;
  int          checks = 0, failures = 0;
  int          done_cnt = 0, done_base = 0, n_pkts = 0;
  int          stab_seen = 0, stab_bad = 0;
  int          stall_cnt = 0;
  int          rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;

  function automatic logic [63:0] model_in(input logic [63:0] d);
`ifdef FLIP_EN
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (aresetn) begin
      if (prev_stall) begin
        stab_seen++;
        if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat) stab_bad++;
      end
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
      if (pkt_done) done_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_word(input logic [63:0] d, input logic last);
    int bud;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    #1;
    bud = 0;
    while (!s_axis_tready && bud < 200) begin
      stall_cnt++;
      @(negedge clk);
      #1;
      bud++;
    end
    if (bud >= 200) check("in_timeout", 64'(bud), 64'(0));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = {$urandom, $urandom};
    s_axis_tlast  = 1'($urandom);
  endtask

  // Model: every word passes (possibly byte-reversed), then {count, folded sum} with tlast.
  task automatic send_pkt(input int gap_pct);
    logic [63:0] sum = '0;
    foreach (pkt_q[i]) begin
      exp_q.push_back({1'b0, model_in(pkt_q[i])});
      sum += model_in(pkt_q[i]);
    end
    exp_q.push_back({1'b1, 32'(pkt_q.size()), sum[63:32] ^ sum[31:0]});
    n_pkts++;
    foreach (pkt_q[i]) begin
      if ($urandom_range(0, 99) < gap_pct) idle_cycle();
      drive_word(pkt_q[i], i == pkt_q.size() - 1);
    end
  endtask

  task automatic drain_and_compare(input string tag);
    int bud = 0;
    while ((got_q.size() - g_rd) < (exp_q.size() - e_rd) && bud < 2000) begin
      @(negedge clk);
      bud++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_beats"}, 64'(got_q.size() - g_rd), 64'(exp_q.size() - e_rd));
    while (e_rd < exp_q.size() && g_rd < got_q.size()) begin
      check({tag, "_beat"}, got_q[g_rd][63:0], exp_q[e_rd][63:0]);
      if (got_q[g_rd][64] !== exp_q[e_rd][64]) check({tag, "_tlast"}, 64'(got_q[g_rd][64]), 64'(exp_q[e_rd][64]));
      g_rd++;
      e_rd++;
    end
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(n_pkts));
    check({tag, "_pkt_done"}, 64'(done_cnt - done_base), 64'(n_pkts));
    check({tag, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic set_vec(input int idx, input int n, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3, input logic [63:0] trl);
    tbl[idx].n    = n;
    tbl[idx].w[0] = w0;
    tbl[idx].w[1] = w1;
    tbl[idx].w[2] = w2;
    tbl[idx].w[3] = w3;
    tbl[idx].trl  = trl;
  endtask

  initial begin
`ifdef FLIP_EN
    set_vec(0, 1, 64'h0000000100000002, 0, 0, 0, 64'h0000000103000000);
    set_vec(1, 4, 64'h1, 64'h2, 64'h3, 64'h4, 64'h000000040A000000);
    set_vec(2, 2, 64'hFFFFFFFFFFFFFFFF, 64'h2, 0, 0, 64'h00000002FE000000);
    set_vec(3, 1, 64'h0102030405060708, 0, 0, 0, 64'h000000010C040404);
`else
    set_vec(0, 1, 64'h0000000100000002, 0, 0, 0, 64'h0000000100000003);
    set_vec(1, 4, 64'h1, 64'h2, 64'h3, 64'h4, 64'h000000040000000A);
    set_vec(2, 2, 64'hFFFFFFFFFFFFFFFF, 64'h2, 0, 0, 64'h0000000200000001);
    set_vec(3, 1, 64'h0102030405060708, 0, 0, 0, 64'h000000010404040C);
`endif

    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_pkt_done", 64'(pkt_done), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tready", 64'(s_axis_tready), 64'(1));
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    rdy_mode = 0;
    for (int t = 0; t < 4; t++) begin
      pkt_q.delete();
      for (int i = 0; i < tbl[t].n; i++) pkt_q.push_back(tbl[t].w[i]);
      send_pkt(0);
      idle_cycle();
      drain_and_compare($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_trailer", t), got_q[got_q.size() - 1][63:0], tbl[t].trl);
    end

    // Back-to-back packets with the sink always ready: exactly one input stall for the trailer.
    stall_cnt = 0;
    pkt_q = '{64'h1, 64'h2, 64'h3, 64'h4};
    send_pkt(0);
    pkt_q = '{64'h7};
    send_pkt(0);
    idle_cycle();
    check("b2b_stalls", 64'(stall_cnt), 64'(1));
    drain_and_compare("b2b");

    rdy_mode = 1;
    pkt_q = '{64'h1, 64'h2, 64'h3, 64'h4};
    send_pkt(0);
    idle_cycle();
    drain_and_compare("alt");
    check("alt_trailer", got_q[got_q.size() - 1][63:0], tbl[1].trl);

    // Reset in the middle of a packet: partial data is dropped, no trailer follows.
    rdy_mode = 0;
    drive_word(64'h11, 1'b0);
    drive_word(64'h22, 1'b0);
    @(negedge clk);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_pkt_count", 64'(pkt_count), 64'(0));
    exp_q.delete();
    e_rd = 0;
    g_rd = got_q.size();
    done_base = done_cnt;
    n_pkts = 0;
    @(negedge clk);
    aresetn = 1'b1;
    pkt_q = '{64'h5};
    send_pkt(0);
    idle_cycle();
    drain_and_compare("post_rst");
`ifdef FLIP_EN
    check("post_rst_trailer", got_q[got_q.size() - 1][63:0], 64'h0000000105000000);
`else
    check("post_rst_trailer", got_q[got_q.size() - 1][63:0], 64'h0000000100000005);
`endif

    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      pkt_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        pkt_q.push_back(($urandom_range(0, 5) == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom});
      send_pkt(25);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    drain_and_compare("rand");

    check("stall_stable", 64'(stab_bad), 64'(0));
    check("stall_seen", 64'(stab_seen > 0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
